// File: rtl/data_mem_responder.sv
// Load/store responder for the datapath: owns the data RAM, adds a fixed access latency
// with Stall back-pressure, and performs RV32I byte/half/word sizing with extension.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Ready,
    output logic              Stall,
    output logic              MisalignErr
);

    localparam int unsigned Depth = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              store_q, store_d;
    logic              err_q, err_d;

    logic [31:0] mem [Depth];

    logic req;
    logic acc_half, acc_word, acc_illegal, acc_misalign, acc_err;

    assign req = MemRead | MemWrite;

    // Access legality is judged on the request as issued, then carried to DONE.
    always_comb begin
        acc_half     = (Funct3[1:0] == 2'b01);
        acc_word     = (Funct3[1:0] == 2'b10);
        acc_illegal  = MemWrite ? (Funct3 > 3'd2)
                                : ((Funct3[1:0] == 2'b11) || (Funct3 == 3'b110));
        acc_misalign = (acc_half && Addr[0]) || (acc_word && (Addr[1:0] != 2'b00));
        acc_err      = (MemRead && MemWrite) || acc_illegal || acc_misalign;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        store_d = store_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = Addr;
                    f3_d    = Funct3;
                    wdata_d = WriteData;
                    store_d = MemWrite;
                    err_d   = acc_err;
                    if (LATENCY == 1) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            store_q <= store_d;
            err_q   <= err_d;
        end
    end

    logic [ADDR_W-3:0] widx;
    logic [1:0]        off;
    logic              done;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wlane;

    assign widx = addr_q[ADDR_W-1:2];
    assign off  = addr_q[1:0];
    assign done = (state_q == StDone) && !reset;
    assign we   = done && store_q && !err_q;

    // Store data is replicated across lanes so the byte enables alone select placement.
    always_comb begin
        be    = 4'b0000;
        wlane = 32'd0;
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;

    always_comb begin
        rword    = mem[widx];
        rbyte    = 8'(rword >> {off, 3'b000});
        rhalf    = off[1] ? rword[31:16] : rword[15:0];
        load_val = 32'd0;
        case (f3_q)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b010:  load_val = rword;
            3'b100:  load_val = {24'd0, rbyte};
            3'b101:  load_val = {16'd0, rhalf};
            default: load_val = 32'd0;
        endcase
    end

    assign Ready       = done;
    assign MisalignErr = done && err_q;
    assign ReadData    = (done && !store_q && !err_q) ? load_val : 32'd0;
    assign Stall       = !reset && (((state_q == StIdle) && req) || (state_q == StWait));

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 2, 4, 1) checked against a
// byte-array memory model and the access rules, plus directed sizing/error/reset cases.
module tb_data_mem_responder;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  mr;
    logic [2:0]  mw;
    logic [2:0]  f3 [3];
    logic [9:0]  ad [3];
    logic [31:0] wd [3];
    logic [31:0] rdata [3];
    logic [2:0]  ready;
    logic [2:0]  stall;
    logic [2:0]  merr;

    int checks = 0;
    int errors = 0;

    logic [7:0] refm [3][64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_W (10),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 4 : 1))
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .MemRead    (mr[g]),
            .MemWrite   (mw[g]),
            .Funct3     (f3[g]),
            .Addr       (ad[g]),
            .WriteData  (wd[g]),
            .ReadData   (rdata[g]),
            .Ready      (ready[g]),
            .Stall      (stall[g]),
            .MisalignErr(merr[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 4 : 1);
    endfunction

    function automatic int size_of(input logic [2:0] f);
        return (f[1:0] == 2'd0) ? 1 : ((f[1:0] == 2'd1) ? 2 : 4);
    endfunction

    function automatic bit exp_err(input bit rd, input bit wr, input logic [2:0] f, input int a);
        bit legal;
        if (rd && wr) return 1'b1;
        if (wr) legal = (f <= 3'd2);
        else    legal = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        if (!legal) return 1'b1;
        return (a % size_of(f)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f, input int a);
        int          sz;
        logic [31:0] v;
        sz = size_of(f);
        v  = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(refm[d][a + i]) << (8 * i));
        if (f < 3'd4 && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    // One complete request: drive, check Stall through the latency window, then the
    // completion cycle, then release the request and update the model.
    task automatic op(input int d, input bit rd, input bit wr, input logic [2:0] f,
                      input int a, input logic [31:0] w, output logic [31:0] got);
        int          lat;
        bit          e;
        logic [31:0] exp_rd;
        lat    = lat_of(d);
        e      = exp_err(rd, wr, f, a);
        exp_rd = (rd && !wr && !e) ? model_load(d, f, a) : 32'd0;
        @(posedge clk); #1;
        mr[d] = rd; mw[d] = wr; f3[d] = f; ad[d] = 10'(a); wd[d] = w;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk($sformatf("d%0d stall c%0d", d, k), {31'd0, stall[d]}, 32'd1);
            chk($sformatf("d%0d early_ready c%0d", d, k), {31'd0, ready[d]}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk($sformatf("d%0d ready a=%0d", d, a), {31'd0, ready[d]}, 32'd1);
        chk($sformatf("d%0d done_stall", d), {31'd0, stall[d]}, 32'd0);
        chk($sformatf("d%0d merr f=%0d a=%0d", d, f, a), {31'd0, merr[d]}, {31'd0, e});
        chk($sformatf("d%0d rdata f=%0d a=%0d", d, f, a), rdata[d], exp_rd);
        got = rdata[d];
        @(posedge clk); #1;
        mr[d] = 1'b0; mw[d] = 1'b0;
        if (wr && !rd && !e) begin
            for (int i = 0; i < size_of(f); i++) refm[d][a + i] = 8'(w >> (8 * i));
        end
    endtask

    logic [31:0] got;
    int          a;
    int          sel;
    logic [2:0]  f;

    initial begin
        rst = 3'b111; mr = 3'b000; mw = 3'b000;
        for (int d = 0; d < 3; d++) begin
            f3[d] = 3'd0; ad[d] = 10'd0; wd[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 3'b000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d rst_ready", d), {31'd0, ready[d]}, 32'd0);
            chk($sformatf("d%0d rst_stall", d), {31'd0, stall[d]}, 32'd0);
            chk($sformatf("d%0d rst_merr", d), {31'd0, merr[d]}, 32'd0);
            chk($sformatf("d%0d rst_rdata", d), rdata[d], 32'd0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 16; w++) op(d, 1'b0, 1'b1, 3'd2, w * 4, $urandom, got);
        end

        // Directed sizing and error cases on the LATENCY=2 instance.
        op(0, 0, 1, 3'd2, 'h10, 32'hDEADBEEF, got);
        op(0, 1, 0, 3'd2, 'h10, 32'd0, got); chk("lw_10", got, 32'hDEADBEEF);
        op(0, 1, 0, 3'd0, 'h13, 32'd0, got); chk("lb_13", got, 32'hFFFFFFDE);
        op(0, 1, 0, 3'd4, 'h13, 32'd0, got); chk("lbu_13", got, 32'h000000DE);
        op(0, 1, 0, 3'd1, 'h10, 32'd0, got); chk("lh_10", got, 32'hFFFFBEEF);
        op(0, 1, 0, 3'd5, 'h12, 32'd0, got); chk("lhu_12", got, 32'h0000DEAD);
        op(0, 0, 1, 3'd0, 'h11, 32'h00000055, got);
        op(0, 1, 0, 3'd2, 'h10, 32'd0, got); chk("lw_after_sb", got, 32'hDEAD55EF);
        op(0, 0, 1, 3'd1, 'h12, 32'h00001234, got);
        op(0, 1, 0, 3'd2, 'h10, 32'd0, got); chk("lw_after_sh", got, 32'h123455EF);
        op(0, 1, 0, 3'd2, 'h12, 32'd0, got); chk("lw_mis_data", got, 32'd0);
        op(0, 0, 1, 3'd1, 'h11, 32'h0000FFFF, got);
        op(0, 1, 0, 3'd3, 'h10, 32'd0, got);
        op(0, 1, 1, 3'd2, 'h10, 32'h0BADF00D, got);
        op(0, 1, 0, 3'd2, 'h10, 32'd0, got); chk("lw_unchanged", got, 32'h123455EF);

        // Reset during the second WAIT cycle of the LATENCY=4 instance abandons the store.
        @(posedge clk); #1;
        mw[1] = 1'b1; mr[1] = 1'b0; f3[1] = 3'd2; ad[1] = 10'h20; wd[1] = 32'hCAFEF00D;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst[1] = 1'b1; mw[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, stall[1]}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready[1]}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_noready c%0d", k), {31'd0, ready[1]}, 32'd0);
        end
        op(1, 1, 0, 3'd2, 'h20, 32'd0, got);

        // LATENCY=1 with MemRead held: DONE and IDLE alternate.
        @(posedge clk); #1;
        mr[2] = 1'b1; f3[2] = 3'd2; ad[2] = 10'h10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("hold_stall c%0d", k), {31'd0, stall[2]}, {31'd0, (k % 2) == 0});
            chk($sformatf("hold_ready c%0d", k), {31'd0, ready[2]}, {31'd0, (k % 2) == 1});
            if ((k % 2) == 1) chk($sformatf("hold_rdata c%0d", k), rdata[2], model_load(2, 3'd2, 'h10));
            @(posedge clk); #1;
        end
        mr[2] = 1'b0;

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                sel = $urandom_range(0, 9);
                f   = 3'($urandom_range(0, 7));
                a   = $urandom_range(0, 63);
                if ($urandom_range(0, 1) == 1) a = a & ~3;
                if (sel < 5)      op(d, 1, 0, f, a, $urandom, got);
                else if (sel < 9) op(d, 0, 1, f, a, $urandom, got);
                else              op(d, 1, 1, f, a, $urandom, got);
            end
            for (int w = 0; w < 16; w++) op(d, 1, 0, 3'd2, w * 4, 32'd0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the datapath memory interface: services the MemRead/MemWrite/MemtoReg load-store requests issued by the control path for LW/SW-class opcodes.
- Holds the data RAM.
- Applies a configurable multi-cycle access latency and back-pressures the core with Stall.
- Performs RV32I byte/half/word sizing with sign or zero extension, and flags misaligned accesses.

Parameters:
- ADDR_W, 10, byte-address width; RAM depth = 2^(ADDR_W-2) 32-bit words.
- LATENCY, 2, cycles from request acceptance to Ready; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request (level; held by requester until Ready).
- MemWrite  in  1  store request (level; held until Ready).
- Funct3  in  3  access size/sign from instruction[14:12].
- Addr  in  ADDR_W  byte address (ALU result low bits).
- WriteData  in  32  store data, right-aligned.
- ReadData  out  32  load result, extended; valid only while Ready=1.
- Ready  out  1  one-cycle completion pulse.
- Stall  out  1  combinational; high while a request is pending or in progress.
- MisalignErr  out  1  pulses with Ready when the access was misaligned or had an illegal Funct3.

Behaviour:
- Reset: state=IDLE, counter=0; ReadData=0, Ready=0, MisalignErr=0, Stall=0. RAM contents are not cleared.
- Reset asserted mid-operation abandons the request. No RAM write occurs, and no Ready is issued.
- FSM states and transitions:
  - IDLE: on (MemRead|MemWrite) capture Addr, Funct3, WriteData and request type; Stall=1 in this same cycle. If LATENCY=1 go to DONE, else load counter=LATENCY-1 and go to WAIT.
  - WAIT: Stall=1; decrement counter each cycle; go to DONE when counter reaches 1. Inputs are ignored.
  - DONE: Stall=0, Ready=1 for exactly one cycle. A store commits to RAM on this cycle's clock edge. Load ReadData is driven this cycle. Next state is IDLE unconditionally; a request still asserted in DONE is the same instruction and is not re-accepted.
- Timing: request seen in IDLE at cycle T gives Stall high in T..T+LATENCY-1, and Ready plus data in cycle T+LATENCY.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE, so minimum spacing is LATENCY+1 cycles.
- MemRead and MemWrite both high: treated as a store, and MisalignErr is pulsed with Ready.
- Sizing uses word index Addr[ADDR_W-1:2] and byte offset Addr[1:0]:
  - Loads: 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW; 100 LBU zero-extend; 101 LHU zero-extend.
  - Stores: 000 SB writes WriteData[7:0] to byte lane Addr[1:0]; 001 SH writes [15:0] to lanes {Addr[1],0} and {Addr[1],1}; 010 SW writes all four lanes. Untouched lanes are preserved.
- Misaligned or illegal access:
  - Misaligned means half access with Addr[0]=1, or word access with Addr[1:0]≠0.
  - Illegal Funct3 means loads 011/110/111, or stores other than 000/001/010.
  - Response: full latency is still observed; no RAM write; ReadData=0; MisalignErr=1 with Ready.
- Outside DONE, ReadData holds 0. Little-endian byte order.

Test Plan:
- LATENCY=2, SW 0xDEADBEEF @0x10 issued at cycle T -> Stall=1 in T and T+1, Ready=1 in T+2. Following LW @0x10 -> ReadData=0xDEADBEEF with Ready, MisalignErr=0.
- After the above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
- SB 0x55 @0x11 over 0xDEADBEEF -> LW @0x10 returns 0xDEAD55EF. SH 0x1234 @0x12 -> LW returns 0x123455EF.
- LW @0x12 and SH @0x11 -> Ready with MisalignErr=1, ReadData=0; subsequent LW @0x10 is unchanged. Funct3=011 load -> MisalignErr=1.
- LATENCY=4, SW issued, reset asserted in the 2nd WAIT cycle -> next cycle Stall=0, Ready=0; no Ready ever appears; the word is unchanged on a later LW.
- LATENCY=1, MemRead held continuously for 6 cycles -> Ready pulses every 2 cycles (DONE/IDLE alternation), Stall=1 exactly in the IDLE cycles.
